fpu_f32_accum_seq: RTL and testbench

//  Sequencer that reduces a valid/ready stream of F32 values into one F32 sum, one burst per I_LAST.

---
 rtl/fpu_f32_accum_seq_if.sv | 28 ++
 rtl/fpu_f32_accum_seq.sv | 73 +++++++
 tb/tb_fpu_f32_accum_seq.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_f32_accum_seq_if.sv
// Stream-in / sum-out / adder-port bundle for the F32 accumulation sequencer.
// slave = sequencer side, master = upstream producer, downstream consumer and adder.
interface fpu_f32_accum_seq_if #(
    parameter int COUNT_W = 16
);
    logic               i_valid;
    logic               i_ready;
    logic [31:0]        i_data;
    logic               i_last;
    logic               o_valid;
    logic               o_ready;
    logic [31:0]        o_data;
    logic [COUNT_W-1:0] o_count;
    logic [31:0]        add_a;
    logic [31:0]        add_b;
    logic [31:0]        add_o;
    logic               busy;

    modport slave (
        input  i_valid, i_data, i_last, o_ready, add_o,
        output i_ready, o_valid, o_data, o_count, add_a, add_b, busy
    );

    modport master (
        output i_valid, i_data, i_last, o_ready, add_o,
        input  i_ready, o_valid, o_data, o_count, add_a, add_b, busy
    );
endinterface

// File: rtl/fpu_f32_accum_seq.sv
// Purpose: left-fold a valid/ready F32 stream into one sum per i_last burst via an external adder.
// Latency: single-element burst -> o_valid next cycle; each further element costs ADD_LATENCY+2 cycles.
// Backpressure: i_ready low while waiting on the adder or holding a result; result held until o_ready.
module fpu_f32_accum_seq #(
    parameter int ADD_LATENCY = 0,
    parameter int COUNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    fpu_f32_accum_seq_if.slave bus
);
    localparam int WCNT_W = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, ACC, WAIT, DONE} state_t;

    state_t             state;
    logic [31:0]        acc_r;
    logic [31:0]        opb_r;
    logic [COUNT_W-1:0] cnt;
    logic [WCNT_W-1:0]  wcnt;
    logic               last_r;
    logic               in_rdy;
    logic               in_xfer;

    assign in_rdy  = ((state == IDLE) || (state == ACC)) && !rst;
    assign in_xfer = bus.i_valid && in_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            acc_r  <= '0;
            opb_r  <= '0;
            cnt    <= '0;
            wcnt   <= '0;
            last_r <= 1'b0;
        end else begin
            case (state)
                // First element seeds the accumulator untouched, so -0 and NaN payloads survive.
                IDLE: if (in_xfer) begin
                    acc_r <= bus.i_data;
                    cnt   <= COUNT_W'(1);
                    state <= bus.i_last ? DONE : ACC;
                end
                ACC: if (in_xfer) begin
                    opb_r  <= bus.i_data;
                    last_r <= bus.i_last;
                    if (cnt != '1)
                        cnt <= cnt + COUNT_W'(1);
                    wcnt   <= WCNT_W'(ADD_LATENCY);
                    state  <= WAIT;
                end
                // add_a/add_b stay frozen here until the adder result is captured.
                WAIT: if (wcnt != '0) begin
                    wcnt <= wcnt - WCNT_W'(1);
                end else begin
                    acc_r <= bus.add_o;
                    state <= last_r ? DONE : ACC;
                end
                DONE: if (bus.o_ready)
                    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i_ready = in_rdy;
    assign bus.o_valid = (state == DONE);
    assign bus.o_data  = acc_r;
    assign bus.o_count = cnt;
    assign bus.add_a   = acc_r;
    assign bus.add_b   = opb_r;
    assign bus.busy    = (state != IDLE);
endmodule

// File: tb/tb_fpu_f32_accum_seq.sv
// Bench for fpu_f32_accum_seq: three instances (latency 0, latency 3, 2-bit counter) sharing one stimulus
// path selected by sel; expected sums come from integer arithmetic and fixed constants.
module tb_fpu_f32_accum_seq;
    logic        clk = 1'b0;
    logic        rst;
    logic        iv;
    logic [31:0] id;
    logic        il;
    logic        ordy;
    int          sel;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    fpu_f32_accum_seq_if #(.COUNT_W(16)) bus_l0 ();
    fpu_f32_accum_seq_if #(.COUNT_W(16)) bus_l3 ();
    fpu_f32_accum_seq_if #(.COUNT_W(2))  bus_c2 ();

    fpu_f32_accum_seq #(.ADD_LATENCY(0), .COUNT_W(16)) dut_l0 (.clk(clk), .rst(rst), .bus(bus_l0));
    fpu_f32_accum_seq #(.ADD_LATENCY(3), .COUNT_W(16)) dut_l3 (.clk(clk), .rst(rst), .bus(bus_l3));
    fpu_f32_accum_seq #(.ADD_LATENCY(0), .COUNT_W(2))  dut_c2 (.clk(clk), .rst(rst), .bus(bus_c2));

    // Adder model: F32 <-> double conversion, exact for the integer-valued operands used here.
    function automatic real f32_to_real(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] real_to_f32(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] int_to_f32(input int n);
        return real_to_f32($itor(n));
    endfunction

    function automatic logic [31:0] f32add(input logic [31:0] a, input logic [31:0] b);
        return real_to_f32(f32_to_real(a) + f32_to_real(b));
    endfunction

    assign bus_l0.add_o = f32add(bus_l0.add_a, bus_l0.add_b);
    assign bus_c2.add_o = f32add(bus_c2.add_a, bus_c2.add_b);

    logic [31:0] p0, p1, p2;
    always @(posedge clk) begin
        p0 <= f32add(bus_l3.add_a, bus_l3.add_b);
        p1 <= p0;
        p2 <= p1;
    end
    assign bus_l3.add_o = p2;

    assign bus_l0.i_valid = iv && (sel == 0);
    assign bus_l3.i_valid = iv && (sel == 1);
    assign bus_c2.i_valid = iv && (sel == 2);
    assign bus_l0.o_ready = ordy && (sel == 0);
    assign bus_l3.o_ready = ordy && (sel == 1);
    assign bus_c2.o_ready = ordy && (sel == 2);
    assign bus_l0.i_data = id;
    assign bus_l3.i_data = id;
    assign bus_c2.i_data = id;
    assign bus_l0.i_last = il;
    assign bus_l3.i_last = il;
    assign bus_c2.i_last = il;

    logic        ir, ov, bsy;
    logic [31:0] od, aa, ab;
    logic [15:0] oc;
    always_comb begin
        ir = bus_l0.i_ready; ov = bus_l0.o_valid; od = bus_l0.o_data;
        oc = bus_l0.o_count; aa = bus_l0.add_a; ab = bus_l0.add_b; bsy = bus_l0.busy;
        if (sel == 1) begin
            ir = bus_l3.i_ready; ov = bus_l3.o_valid; od = bus_l3.o_data;
            oc = bus_l3.o_count; aa = bus_l3.add_a; ab = bus_l3.add_b; bsy = bus_l3.busy;
        end else if (sel == 2) begin
            ir = bus_c2.i_ready; ov = bus_c2.o_valid; od = bus_c2.o_data;
            oc = 16'(bus_c2.o_count); aa = bus_c2.add_a; ab = bus_c2.add_b; bsy = bus_c2.busy;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (sel=%0d t=%0t)", nm, act, exp, sel, $time);
        end
    endtask

    task automatic set_sel(input int s);
        sel = s;
        #1;
    endtask

    // Offers one element; returns how many sampled cycles i_ready was low before acceptance.
    task automatic push(input logic [31:0] d, input logic l, output int lowcyc);
        lowcyc = 0;
        iv = 1'b1; id = d; il = l;
        while (!ir && lowcyc < 200) begin
            @(posedge clk); #1;
            lowcyc++;
        end
        chk("push_timeout", {31'd0, ir}, 32'd1);
        @(posedge clk); #1;
        iv = 1'b0;
    endtask

    task automatic get_result(input int hold, output logic [31:0] d, output logic [15:0] c,
                              output int waited);
        waited = 0;
        ordy = 1'b0;
        while (!ov && waited < 300) begin
            @(posedge clk); #1;
            waited++;
        end
        chk("result_timeout", {31'd0, ov}, 32'd1);
        d = od;
        c = oc;
        repeat (hold) begin @(posedge clk); #1; end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_i_ready"}, {31'd0, ir},  32'd0);
        chk({tag, "_o_valid"}, {31'd0, ov},  32'd0);
        chk({tag, "_o_data"},  od,           32'd0);
        chk({tag, "_o_count"}, {16'd0, oc},  32'd0);
        chk({tag, "_add_a"},   aa,           32'd0);
        chk({tag, "_add_b"},   ab,           32'd0);
        chk({tag, "_busy"},    {31'd0, bsy}, 32'd0);
    endtask

    typedef struct {
        int               sel;
        int               n;
        logic [4:0][31:0] d;
        logic [31:0]      exp_sum;
        int               exp_cnt;
    } vec_t;

    vec_t vt [8];

    task automatic set_vec(input int i, input int s, input int n, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                           input logic [31:0] d4, input logic [31:0] es, input int ec);
        vt[i].sel = s; vt[i].n = n;
        vt[i].d[0] = d0; vt[i].d[1] = d1; vt[i].d[2] = d2; vt[i].d[3] = d3; vt[i].d[4] = d4;
        vt[i].exp_sum = es; vt[i].exp_cnt = ec;
    endtask

    function automatic int lat_of(input int s);
        return (s == 1) ? 3 : 0;
    endfunction

    int          lowc, waited, s, len, sum, v, satmax;
    logic [31:0] rd, hd;
    logic [15:0] rc, hc;

    initial begin
        rst = 1'b1; iv = 1'b0; id = '0; il = 1'b0; ordy = 1'b0; sel = 0;

        set_vec(0, 0, 1, 32'h3F800000, 0, 0, 0, 0, 32'h3F800000, 1);
        set_vec(1, 0, 3, 32'h3F800000, 32'h40000000, 32'h40400000, 0, 0, 32'h40C00000, 3);
        set_vec(2, 1, 4, 32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000, 0, 32'h40000000, 4);
        set_vec(3, 2, 5, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000,
                32'h40A00000, 3);
        set_vec(4, 0, 1, 32'h80000000, 0, 0, 0, 0, 32'h80000000, 1);
        set_vec(5, 0, 1, 32'h7FC12345, 0, 0, 0, 0, 32'h7FC12345, 1);
        set_vec(6, 1, 1, 32'hFF800001, 0, 0, 0, 0, 32'hFF800001, 1);
        set_vec(7, 1, 2, 32'h40400000, 32'hC0400000, 0, 0, 0, 32'h00000000, 2);

        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            set_sel(k);
            chk_reset_outputs("reset");
        end
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            set_sel(k);
            chk("ready_after_reset", {31'd0, ir}, 32'd1);
        end
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) begin
            set_sel(vt[t].sel);
            for (int k = 0; k < vt[t].n; k++) begin
                push(vt[t].d[k], (k == vt[t].n - 1), lowc);
                if (k >= 1)
                    chk("ready_low_cycles", lowc, (k == 1) ? 0 : lat_of(vt[t].sel) + 1);
            end
            get_result(0, rd, rc, waited);
            chk("result_latency", waited, (vt[t].n == 1) ? 0 : lat_of(vt[t].sel) + 1);
            chk("vec_sum", rd, vt[t].exp_sum);
            chk("vec_count", {16'd0, rc}, vt[t].exp_cnt);
        end

        // Result held for 5 cycles with o_ready low.
        set_sel(0);
        push(32'h40000000, 1'b1, lowc);
        hd = od; hc = oc;
        chk("hold_data_first", hd, 32'h40000000);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'd0, ov}, 32'd1);
            chk("hold_data", od, hd);
            chk("hold_count", {16'd0, oc}, {16'd0, hc});
            chk("hold_in_ready", {31'd0, ir}, 32'd0);
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        chk("release_valid", {31'd0, ov}, 32'd0);
        chk("release_in_ready", {31'd0, ir}, 32'd1);
        chk("release_busy", {31'd0, bsy}, 32'd0);

        // Reset while the latency-3 instance waits on its adder.
        set_sel(1);
        push(32'h3F800000, 1'b0, lowc);
        push(32'h40000000, 1'b0, lowc);
        chk("wait_add_a", aa, 32'h3F800000);
        chk("wait_add_b", ab, 32'h40000000);
        chk("wait_busy", {31'd0, bsy}, 32'd1);
        @(posedge clk); #1;
        chk("wait_add_a_stable", aa, 32'h3F800000);
        chk("wait_add_b_stable", ab, 32'h40000000);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset_outputs("midburst_reset");
        rst = 1'b0;
        #1;
        push(32'h40400000, 1'b1, lowc);
        get_result(0, rd, rc, waited);
        chk("post_reset_sum", rd, 32'h40400000);
        chk("post_reset_count", {16'd0, rc}, 32'd1);

        // Random bursts of small integers; reference is the integer sum.
        for (int b = 0; b < 24; b++) begin
            s = $urandom_range(0, 2);
            len = $urandom_range(1, 7);
            sum = 0;
            set_sel(s);
            for (int k = 0; k < len; k++) begin
                v = int'($urandom_range(0, 2000)) - 1000;
                sum += v;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                push(int_to_f32(v), (k == len - 1), lowc);
            end
            get_result($urandom_range(0, 3), rd, rc, waited);
            satmax = (s == 2) ? 3 : 65535;
            chk("rand_sum", rd, int_to_f32(sum));
            chk("rand_count", {16'd0, rc}, (len < satmax) ? len : satmax);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
